// File: rtl/ptw_mem_responder.sv
// ptw_mem_responder: serves page-table walker PTE reads over a
// simple req/gnt/rvalid memory port, one read in flight at a time.

package ptw_pkg;

    localparam int SIZE_VADDR = 39;

    typedef struct packed {
        logic                  valid;
        logic [SIZE_VADDR:0]   addr;
        logic [4:0]            cmd;
        logic [3:0]            typ;
        logic                  phys;
        logic                  kill;
    } ptw_dmem_req_t;

    typedef struct packed {
        ptw_dmem_req_t req;
    } ptw_dmem_comm_t;

    typedef struct packed {
        logic        valid;
        logic        nack;
        logic        replay;
        logic [63:0] data;
    } dmem_ptw_resp_t;

    typedef struct packed {
        logic           dmem_ready;
        dmem_ptw_resp_t resp;
    } dmem_ptw_comm_t;

endpackage

module ptw_mem_responder
    import ptw_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int PADDR_W        = SIZE_VADDR + 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  ptw_dmem_comm_t     ptw_dmem_comm_i,
    output dmem_ptw_comm_t     dmem_ptw_comm_o,
    output logic               mem_req_o,
    output logic [PADDR_W-1:0] mem_addr_o,
    input  logic               mem_gnt_i,
    input  logic               mem_rvalid_i,
    input  logic [63:0]        mem_rdata_i,
    input  logic               mem_rerr_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_NACK
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t               state_q, state_d;
    logic                 drain_q, drain_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [63:0]          data_q, data_d;
    logic [PADDR_W-1:0]   addr_q, addr_d;
    logic                 req_legal;

    // Legality is judged on exactly the fields captured at acceptance,
    // so the illegal case can nack on the very next cycle.
    assign req_legal = (ptw_dmem_comm_i.req.cmd == 5'b00000)
                     && (ptw_dmem_comm_i.req.typ == 4'b0011)
                     && (ptw_dmem_comm_i.req.addr[2:0] == 3'b000)
                     && ptw_dmem_comm_i.req.phys
                     && !ptw_dmem_comm_i.req.kill;

    // State, drain flag, timeout counter and capture registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            drain_q <= 1'b0;
            cnt_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state: a timed-out read leaves one beat outstanding, which
    // drain_q swallows wherever it turns up.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        addr_d  = addr_q;

        if (mem_rvalid_i && drain_q) begin
            drain_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (ptw_dmem_comm_i.req.valid) begin
                    addr_d  = PADDR_W'(ptw_dmem_comm_i.req.addr);
                    state_d = req_legal ? S_ISSUE : S_NACK;
                end
            end
            S_ISSUE: begin
                if (mem_gnt_i) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (mem_rvalid_i && !drain_q) begin
                    if (mem_rerr_i) begin
                        state_d = S_NACK;
                    end else begin
                        data_d  = mem_rdata_i;
                        state_d = S_RESP;
                    end
                end else if (!mem_rvalid_i && (cnt_q >= CNT_LAST)) begin
                    drain_d = 1'b1;
                    state_d = S_NACK;
                end
            end
            S_RESP: state_d = S_IDLE;
            S_NACK: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Walker-facing outputs come from state and registers only.
    always_comb begin
        dmem_ptw_comm_o            = '0;
        dmem_ptw_comm_o.dmem_ready = (state_q == S_IDLE);
        dmem_ptw_comm_o.resp.valid = (state_q == S_RESP);
        dmem_ptw_comm_o.resp.nack  = (state_q == S_NACK);
        dmem_ptw_comm_o.resp.data  = (state_q == S_RESP) ? data_q : '0;
    end

    assign mem_req_o  = (state_q == S_ISSUE);
    assign mem_addr_o = {addr_q[PADDR_W-1:3], 3'b000};

endmodule

// File: doc/ptw_mem_responder.md
# ptw_mem_responder

Memory-side responder for the page-table walker's dmem port. It accepts one PTE read at a time from the walker and checks that the request is legal. It then performs the read on a simple req/gnt/rvalid memory port and returns the 64-bit PTE, or a nack that makes the walker retry. It sits between the MMU page-table walker and the L1/L2 memory fabric, and replaces a full data-cache port for page-table traffic.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 255: maximum cycles in S_WAIT before a nack is forced (range 1..65535).
- PADDR_W, default SIZE_VADDR+1: width of mem_addr_o.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- ptw_dmem_comm_i  in  ptw_dmem_comm_t  walker request. Fields used: req.valid, req.addr, req.cmd, req.typ, req.phys, req.kill.
- dmem_ptw_comm_o  out  dmem_ptw_comm_t  response to the walker. Fields driven: dmem_ready, resp.valid, resp.nack, resp.data; all other fields are 0.
- mem_req_o  out  1  memory read request; held until granted.
- mem_addr_o  out  PADDR_W  read address; bits [2:0] always 0.
- mem_gnt_i  in  1  memory accepted the request this cycle.
- mem_rvalid_i  in  1  read data valid. The memory returns data in order, exactly once per grant.
- mem_rdata_i  in  64  read data.
- mem_rerr_i  in  1  bus error; qualified by mem_rvalid_i.

## Operation
- States: S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_NACK.
- Acceptance: a request is accepted when req.valid && dmem_ready. dmem_ready = (state == S_IDLE). On acceptance, addr, cmd, typ, phys and kill are captured into registers.
- Legality, evaluated on the captured fields:
  - cmd == 5'b00000 (M_XRD);
  - typ == 4'b0011 (MT_D);
  - addr[2:0] == 0;
  - phys == 1;
  - kill == 0.
- S_IDLE -> S_ISSUE if the captured request is legal, otherwise -> S_NACK.
- S_ISSUE: mem_req_o = 1, with mem_addr_o = the captured address. On mem_gnt_i -> S_WAIT and the timeout counter is cleared.
- S_WAIT: the counter increments every cycle.
  - mem_rvalid_i && !drain_q && !mem_rerr_i: capture mem_rdata_i into data_q, -> S_RESP.
  - mem_rvalid_i && !drain_q && mem_rerr_i: -> S_NACK.
  - Counter reaches TIMEOUT_CYCLES-1 with no rvalid: set drain_q, -> S_NACK.
- S_RESP: resp.valid = 1, resp.data = data_q, then -> S_IDLE.
- S_NACK: resp.nack = 1, then -> S_IDLE.
- Drain: while drain_q = 1, the first mem_rvalid_i seen in any state is discarded and clears drain_q.
  - In S_WAIT, a beat that clears drain_q does not complete the current request.
  - New requests are still accepted while drain_q is set.
- resp.valid and resp.nack are mutually exclusive one-cycle pulses, and exactly one is produced per accepted request.
- resp.data is 0 whenever resp.valid = 0.

## Timing
- Reset values: state S_IDLE; drain_q 0; counter 0; data_q 0.
- Output values during reset: dmem_ready 1, mem_req_o 0, mem_addr_o 0, resp.valid 0, resp.nack 0, resp.data 0.
- Reset is asynchronous and aborts any operation in flight. No response is produced for an aborted request.
- Latency, with acceptance at cycle T:
  - Illegal request: nack at T+1.
  - Legal request: mem_req_o from T+1. With grant at G and rvalid at R (R > G), resp.valid at R+1.
  - Minimum legal latency (gnt at T+1, rvalid at T+2): resp.valid at T+3.
- Timeout: with grant at G and no rvalid, resp.nack at G+TIMEOUT_CYCLES+1.
- Simultaneous events:
  - rvalid in the same cycle the counter hits its limit: rvalid wins and no timeout occurs.
  - rvalid with mem_rerr_i = 1: nack; data is ignored.
  - A stray rvalid while drain_q = 1 in the grant cycle of S_ISSUE: the stray is consumed and the grant still advances to S_WAIT.
- req.valid while not in S_IDLE is ignored (dmem_ready = 0). The walker holds valid until it sees dmem_ready.
- All outputs are driven from registers or from state only; there are no combinational paths from mem_* inputs to walker outputs.

## Test plan
- Legal read, addr 0x8000_1008, cmd 0, typ 3, phys 1. Memory grants at T+1 and returns 0x0000_0000_2000_0C01 at T+2 -> resp.valid = 1 with that data at T+3, and dmem_ready = 1 again at T+4.
- Misaligned addr 0x8000_1004, then a separate request with cmd 5'b01010 -> each gives resp.nack at T+1, with no mem_req_o pulse.
- Grant delayed 5 cycles; rvalid with mem_rerr_i = 1 -> resp.nack one cycle after rvalid; resp.valid never asserts.
- TIMEOUT_CYCLES = 4, no rvalid -> nack at G+5.
  - Next request is accepted and granted.
  - A late stray rvalid (data 0xDEAD) is discarded, then the real rvalid (data 0x1) -> resp.valid with data 0x1.
- rst_i asserted in S_WAIT -> dmem_ready = 1 and mem_req_o = 0 immediately; no resp.valid or resp.nack afterwards, even if the old rvalid arrives.
- Back-to-back: 3 legal reads issued as soon as dmem_ready returns -> exactly 3 resp.valid pulses, in order, with matching data.
